// File: rtl/ysyx_23060184_lsu_pkg.sv
// Shared definitions for the memory-access stage: load/store width codes,
// FSM state encoding and a funct3 size decoder.
package ysyx_23060184_lsu_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  // Undefined funct3 encodings fall back to a word access.
  function automatic lsu_size_e mem_size(input logic [2:0] funct3);
    lsu_size_e sz;
    case (funct3)
      MEM_B, MEM_BU: sz = SZ_BYTE;
      MEM_H, MEM_HU: sz = SZ_HALF;
      MEM_W:         sz = SZ_WORD;
      default:       sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/ysyx_23060184_lsu_align.sv
// Combinational lane logic: store data replication and byte strobes,
// load byte/half extraction with sign/zero extension, misalignment check.
module ysyx_23060184_lsu_align
  import ysyx_23060184_lsu_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_store_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wmask_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o
);

  lsu_size_e   size_s;
  logic [31:0] byte_word_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign size_s      = mem_size(funct3_i);
  assign byte_word_s = rdata_i >> {lane_i, 3'b000};
  assign byte_s      = byte_word_s[7:0];
  assign half_s      = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Load extraction and extension.
  always_comb begin
    case (funct3_i)
      MEM_B:   load_data_o = {{24{byte_s[7]}}, byte_s};
      MEM_BU:  load_data_o = {24'd0, byte_s};
      MEM_H:   load_data_o = {{16{half_s[15]}}, half_s};
      MEM_HU:  load_data_o = {16'd0, half_s};
      MEM_W:   load_data_o = rdata_i;
      default: load_data_o = rdata_i;
    endcase
  end

  // Store lane replication, strobes and alignment check; loads never strobe.
  always_comb begin
    case (size_s)
      SZ_BYTE: begin
        wdata_o    = {4{store_data_i[7:0]}};
        wmask_o    = 4'b0001 << lane_i;
        misalign_o = 1'b0;
      end
      SZ_HALF: begin
        wdata_o    = {2{store_data_i[15:0]}};
        wmask_o    = 4'b0011 << lane_i;
        misalign_o = lane_i[0];
      end
      default: begin
        wdata_o    = store_data_i;
        wmask_o    = 4'b1111;
        misalign_o = (lane_i != 2'b00);
      end
    endcase
    if (!is_store_i) begin
      wmask_o = 4'b0000;
    end else begin
      wmask_o = wmask_o;
    end
  end

endmodule

// File: rtl/ysyx_23060184_lsu.sv
// Memory-access stage: takes the ALU result, performs the optional data-memory
// access over req/gnt/rvalid and hands the result to write-back.
module ysyx_23060184_lsu
  import ysyx_23060184_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  Evalid,
  output logic                  Mready,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] StoreData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            MemFunct3,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  Mvalid,
  input  logic                  Wready,
  output logic [DATA_WIDTH-1:0] MemResult,
  output logic                  MisAlign
);

  lsu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [2:0]            f3_q, f3_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  mis_q, mis_d;

  logic                  idle_s;
  logic [1:0]            lane_s;
  logic [2:0]            f3_s;
  logic                  store_s;
  logic [DATA_WIDTH-1:0] load_data_s;
  logic [DATA_WIDTH-1:0] resp_s;
  logic                  mis_s;

  // In IDLE the aligner looks at the incoming op so misalignment is known at capture.
  assign idle_s  = (state_q == S_IDLE);
  assign lane_s  = idle_s ? ALUResult[1:0] : addr_q[1:0];
  assign f3_s    = idle_s ? MemFunct3 : f3_q;
  assign store_s = idle_s ? MemWrite : wr_q;

  ysyx_23060184_lsu_align u_align (
    .lane_i       (lane_s),
    .funct3_i     (f3_s),
    .is_store_i   (store_s),
    .store_data_i (sdata_q),
    .rdata_i      (mem_rdata),
    .wdata_o      (mem_wdata),
    .wmask_o      (mem_wmask),
    .load_data_o  (load_data_s),
    .misalign_o   (mis_s)
  );

  assign resp_s    = wr_q ? {DATA_WIDTH{1'b0}} : load_data_s;
  assign Mready    = idle_s;
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = wr_q;
  assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign Mvalid    = (state_q == S_DONE);
  assign MemResult = result_q;
  assign MisAlign  = mis_q;

  // Next-state and capture logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    f3_d     = f3_q;
    result_d = result_q;
    mis_d    = mis_q;
    case (state_q)
      S_IDLE: begin
        if (Evalid) begin
          addr_d  = ALUResult;
          sdata_d = StoreData;
          rd_d    = MemRead;
          wr_d    = MemWrite;
          f3_d    = MemFunct3;
          if (!MemRead && !MemWrite) begin
            result_d = ALUResult;
            mis_d    = 1'b0;
            state_d  = S_DONE;
          end else if (mis_s) begin
            result_d = {DATA_WIDTH{1'b0}};
            mis_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            mis_d    = 1'b0;
            state_d  = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_gnt && mem_rvalid) begin
          result_d = resp_s;
          state_d  = S_DONE;
        end else if (mem_gnt) begin
          state_d  = S_WAIT;
        end else begin
          state_d  = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          result_d = resp_s;
          state_d  = S_DONE;
        end else begin
          state_d  = S_WAIT;
        end
      end
      S_DONE: begin
        if (Wready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and operand registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      addr_q   <= {DATA_WIDTH{1'b0}};
      sdata_q  <= {DATA_WIDTH{1'b0}};
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      f3_q     <= 3'b000;
      result_q <= {DATA_WIDTH{1'b0}};
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sdata_q  <= sdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      f3_q     <= f3_d;
      result_q <= result_d;
      mis_q    <= mis_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_lsu.sv
// Directed bench for the memory-access stage: a vector table of ops with
// hand-computed bus and result expectations, plus a mid-transaction reset.
module tb_ysyx_23060184_lsu;

  logic        clk;
  logic        rstn;
  logic        Evalid;
  logic        Mready;
  logic [31:0] ALUResult;
  logic [31:0] StoreData;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  MemFunct3;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        Mvalid;
  logic        Wready;
  logic [31:0] MemResult;
  logic        MisAlign;

  int n_cmp;
  int n_err;

  ysyx_23060184_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .Evalid(Evalid), .Mready(Mready),
    .ALUResult(ALUResult), .StoreData(StoreData), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemFunct3(MemFunct3), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .Mvalid(Mvalid), .Wready(Wready),
    .MemResult(MemResult), .MisAlign(MisAlign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    int          wr_dly;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_result;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    @(negedge clk);
    check({v.name, " mready_idle"}, {31'd0, Mready}, 32'd1);
    Evalid    = 1'b1;
    ALUResult = v.alu;
    StoreData = v.sdata;
    MemRead   = v.rd;
    MemWrite  = v.wr;
    MemFunct3 = v.f3;
    mem_rdata = v.rdata;
    @(negedge clk);
    Evalid    = 1'b0;
    ALUResult = 32'hDEAD_0000;
    StoreData = 32'h5555_5555;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    if (v.exp_req) begin
      check({v.name, " mvalid_busy"}, {31'd0, Mvalid}, 32'd0);
      for (int i = 0; i < v.gnt_dly; i++) begin
        check({v.name, " req_stall"}, {31'd0, mem_req}, 32'd1);
        check({v.name, " addr_stall"}, mem_addr, v.exp_addr);
        @(negedge clk);
      end
      check({v.name, " req"}, {31'd0, mem_req}, 32'd1);
      check({v.name, " addr"}, mem_addr, v.exp_addr);
      check({v.name, " we"}, {31'd0, mem_we}, {31'd0, v.exp_we});
      check({v.name, " wmask"}, {28'd0, mem_wmask}, {28'd0, v.exp_wmask});
      if (v.exp_we) begin
        check({v.name, " wdata"}, mem_wdata, v.exp_wdata);
      end else begin
        check({v.name, " mready_busy"}, {31'd0, Mready}, 32'd0);
      end
      mem_gnt    = 1'b1;
      mem_rvalid = (v.rv_dly == 0);
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (v.rv_dly > 0) begin
        for (int i = 1; i < v.rv_dly; i++) begin
          check({v.name, " req_wait"}, {31'd0, mem_req}, 32'd0);
          check({v.name, " mvalid_wait"}, {31'd0, Mvalid}, 32'd0);
          @(negedge clk);
        end
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
    end else begin
      check({v.name, " no_req"}, {31'd0, mem_req}, 32'd0);
    end
    check({v.name, " mvalid"}, {31'd0, Mvalid}, 32'd1);
    check({v.name, " result"}, MemResult, v.exp_result);
    check({v.name, " misalign"}, {31'd0, MisAlign}, {31'd0, v.exp_mis});
    for (int i = 0; i < v.wr_dly; i++) begin
      @(negedge clk);
      check({v.name, " mvalid_hold"}, {31'd0, Mvalid}, 32'd1);
      check({v.name, " result_hold"}, MemResult, v.exp_result);
      check({v.name, " mis_hold"}, {31'd0, MisAlign}, {31'd0, v.exp_mis});
      check({v.name, " mready_hold"}, {31'd0, Mready}, 32'd0);
    end
    Wready = 1'b1;
    @(negedge clk);
    Wready = 1'b0;
    check({v.name, " mvalid_drop"}, {31'd0, Mvalid}, 32'd0);
    check({v.name, " mready_back"}, {31'd0, Mready}, 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rstn = 1'b1; Evalid = 1'b0; ALUResult = 32'd0; StoreData = 32'd0;
    MemRead = 1'b0; MemWrite = 1'b0; MemFunct3 = 3'b000;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; Wready = 1'b0;

    //         name     alu           sdata         rd    wr    f3      rdata        g  r  w  req   addr          we    wmask    wdata         result        mis
    vecs[0]  = '{"nonmem", 32'h1234_5678, 32'h0,        1'b0, 1'b0, 3'b000, 32'h0,       0, 0, 0, 1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h1234_5678, 1'b0};
    vecs[1]  = '{"lb",     32'h8000_0003, 32'h0,        1'b1, 1'b0, 3'b000, 32'h80AA_BBCC, 2, 3, 0, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{"lhu",    32'h8000_0002, 32'h0,        1'b1, 1'b0, 3'b101, 32'hBEEF_1234, 0, 0, 0, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'h0000_BEEF, 1'b0};
    vecs[3]  = '{"sb",     32'h8000_0001, 32'h0000_00A5, 1'b0, 1'b1, 3'b000, 32'h0,      1, 1, 0, 1'b1, 32'h8000_0000, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0};
    vecs[4]  = '{"sw_mis", 32'h8000_0002, 32'h1111_2222, 1'b0, 1'b1, 3'b010, 32'h0,      0, 0, 4, 1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[5]  = '{"lh",     32'h8000_0000, 32'h0,        1'b1, 1'b0, 3'b001, 32'h1234_8001, 0, 2, 1, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0};
    vecs[6]  = '{"lw",     32'h8000_0004, 32'h0,        1'b1, 1'b0, 3'b010, 32'hDEAD_BEEF, 1, 1, 0, 1'b1, 32'h8000_0004, 1'b0, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0};
    vecs[7]  = '{"lbu",    32'h8000_0001, 32'h0,        1'b1, 1'b0, 3'b100, 32'h80AA_BBCC, 0, 1, 0, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'h0000_00BB, 1'b0};
    vecs[8]  = '{"sh",     32'h8000_0002, 32'h1234_ABCD, 1'b0, 1'b1, 3'b001, 32'h0,      0, 0, 0, 1'b1, 32'h8000_0000, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0};
    vecs[9]  = '{"sw",     32'h8000_0008, 32'hCAFE_F00D, 1'b0, 1'b1, 3'b010, 32'h0,      2, 2, 0, 1'b1, 32'h8000_0008, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0};
    vecs[10] = '{"lh_mis", 32'h8000_0001, 32'h0,        1'b1, 1'b0, 3'b001, 32'h0,       0, 0, 1, 1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{"f3_011", 32'h8000_0000, 32'h0,        1'b1, 1'b0, 3'b011, 32'h1122_3344, 0, 1, 0, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'h1122_3344, 1'b0};
    vecs[12] = '{"rd_wr",  32'h8000_0000, 32'h0000_0077, 1'b1, 1'b1, 3'b000, 32'hFFFF_FFFF, 0, 1, 0, 1'b1, 32'h8000_0000, 1'b1, 4'b0001, 32'h7777_7777, 32'h0,        1'b0};

    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst mready", {31'd0, Mready}, 32'd1);
    check("rst mvalid", {31'd0, Mvalid}, 32'd0);
    check("rst req", {31'd0, mem_req}, 32'd0);
    check("rst result", MemResult, 32'd0);
    check("rst mis", {31'd0, MisAlign}, 32'd0);
    rstn = 1'b1;

    // A stray response while idle must be ignored.
    @(negedge clk);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("idle_rvalid mvalid", {31'd0, Mvalid}, 32'd0);
    check("idle_rvalid mready", {31'd0, Mready}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i]);
    end

    // Abort a load in WAIT with reset; the late response must not surface.
    @(negedge clk);
    Evalid = 1'b1; ALUResult = 32'h8000_0010; MemRead = 1'b1; MemWrite = 1'b0;
    MemFunct3 = 3'b010; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    Evalid = 1'b0; MemRead = 1'b0;
    check("abort req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("abort wait_req", {31'd0, mem_req}, 32'd0);
    check("abort wait_mready", {31'd0, Mready}, 32'd0);
    #2 rstn = 1'b0;
    #1;
    check("abort async_mready", {31'd0, Mready}, 32'd1);
    check("abort async_req", {31'd0, mem_req}, 32'd0);
    check("abort async_mvalid", {31'd0, Mvalid}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort stray_mvalid", {31'd0, Mvalid}, 32'd0);
      check("abort stray_req", {31'd0, mem_req}, 32'd0);
      check("abort stray_mready", {31'd0, Mready}, 32'd1);
      check("abort stray_result", MemResult, 32'd0);
      @(negedge clk);
    end

    run_op(vecs[0]);
    run_op(vecs[7]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
